// File: rtl/memory_cycle.sv
`default_nettype none
// ============================================================================
// Module   : memory_cycle
// Brief    : RV32I MEM stage - sized load/store to a word-organised data
//            memory, load extension, misalignment detection, MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
module memory_cycle #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic        StallM,
    input  logic        FlushM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic        MisalignW
);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;
    localparam logic [1:0] c_SRC_LOAD = 2'b01;

    logic [31:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] w_wordIdx;
    logic [1:0]        w_lane;
    logic              w_isLoad;
    logic              w_misalign;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_loadData;
    logic [3:0]        w_byteEn;
    logic [31:0]       w_storeData;
    logic              w_storeEn;
    logic              w_unusedAddr;

    assign w_wordIdx    = ALUResultM[ADDR_W+1:2];
    assign w_lane       = ALUResultM[1:0];
    assign w_unusedAddr = ^ALUResultM[31:ADDR_W+2];
    assign w_isLoad     = (ResultSrcM == c_SRC_LOAD);

    // Only memory accesses can be misaligned; ALU results in other modes are not addresses.
    always_comb begin
        w_misalign = 1'b0;
        if (w_isLoad || MemWriteM) begin
            case (funct3M)
                c_F3_H, c_F3_HU: w_misalign = w_lane[0];
                c_F3_W:          w_misalign = (w_lane != 2'b00);
                default:         w_misalign = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_word     = r_mem[w_wordIdx];
        w_byte     = w_word[8*w_lane +: 8];
        w_half     = w_lane[1] ? w_word[31:16] : w_word[15:0];
        w_loadData = 32'h0;
        case (funct3M)
            c_F3_B:  w_loadData = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_loadData = {{16{w_half[15]}}, w_half};
            c_F3_W:  w_loadData = w_word;
            c_F3_BU: w_loadData = {24'h0, w_byte};
            c_F3_HU: w_loadData = {16'h0, w_half};
            default: w_loadData = 32'h0;
        endcase
        if (w_misalign) begin
            w_loadData = 32'h0;
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_byteEn    = 4'b0000;
        w_storeData = WriteDataM;
        case (funct3M)
            c_F3_B: begin
                w_byteEn    = 4'b0001 << w_lane;
                w_storeData = {4{WriteDataM[7:0]}};
            end
            c_F3_H: begin
                w_byteEn    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{WriteDataM[15:0]}};
            end
            c_F3_W:  w_byteEn = 4'b1111;
            default: w_byteEn = 4'b0000;
        endcase
    end

    assign w_storeEn = MemWriteM && !w_misalign && !StallM && !FlushM && rst;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_storeEn && w_byteEn[i]) begin
                r_mem[w_wordIdx][8*i +: 8] <= w_storeData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RD_W       <= 5'd0;
            ALUResultW <= 32'h0;
            ReadDataW  <= 32'h0;
            PCPlus4W   <= 32'h0;
            MisalignW  <= 1'b0;
        end else if (FlushM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RD_W       <= 5'd0;
            ALUResultW <= 32'h0;
            ReadDataW  <= 32'h0;
            PCPlus4W   <= 32'h0;
            MisalignW  <= 1'b0;
        end else if (!StallM) begin
            RegWriteW  <= RegWriteM && !(w_misalign && w_isLoad);
            ResultSrcW <= ResultSrcM;
            RD_W       <= RD_M;
            ALUResultW <= ALUResultM;
            ReadDataW  <= w_loadData;
            PCPlus4W   <= PCPlus4M;
            MisalignW  <= w_misalign;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_cycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_cycle
// Brief    : Directed self-checking bench for memory_cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, StallM, FlushM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic        RegWriteW, MisalignW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;

    int total = 0;
    int bad   = 0;

    memory_cycle #(.DEPTH(1024), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .funct3M(funct3M), .RD_M(RD_M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .StallM(StallM), .FlushM(FlushM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .MisalignW(MisalignW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWriteM = 0; MemWriteM = 0; ResultSrcM = 2'b00; funct3M = 3'b000;
        RD_M = 0; ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0;
        StallM = 0; FlushM = 0;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        idle();
        MemWriteM = 1; funct3M = f3; ALUResultM = addr; WriteDataM = data;
        PCPlus4M = 32'h0000_0100;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        idle();
        RegWriteM = 1; ResultSrcM = 2'b01; funct3M = f3; ALUResultM = addr; RD_M = rd;
        PCPlus4M = 32'h0000_0200;
    endtask

    initial begin
        idle();
        rst = 0;
        step(); step();
        chk("rst_regwrite", {31'h0, RegWriteW}, 32'h0);
        chk("rst_readdata", ReadDataW, 32'h0);
        rst = 1;

        store(3'b010, 32'h10, 32'hDEADBEEF); step();
        chk("sw_regwrite", {31'h0, RegWriteW}, 32'h0);
        chk("sw_alures", ALUResultW, 32'h10);
        chk("sw_pc", PCPlus4W, 32'h100);
        load(3'b010, 32'h10, 5'd5); step();
        chk("lw_data", ReadDataW, 32'hDEADBEEF);
        chk("lw_src", {30'h0, ResultSrcW}, 32'h1);
        chk("lw_regwrite", {31'h0, RegWriteW}, 32'h1);
        chk("lw_rd", {27'h0, RD_W}, 32'd5);
        chk("lw_pc", PCPlus4W, 32'h200);

        store(3'b000, 32'h13, 32'h12345680); step();
        load(3'b000, 32'h13, 5'd6); step();
        chk("lb_sext", ReadDataW, 32'hFFFFFF80);
        load(3'b100, 32'h13, 5'd6); step();
        chk("lbu_zext", ReadDataW, 32'h00000080);
        load(3'b010, 32'h10, 5'd6); step();
        chk("lw_after_sb", ReadDataW, 32'h80ADBEEF);
        store(3'b001, 32'h12, 32'hAAAA8001); step();
        load(3'b001, 32'h12, 5'd6); step();
        chk("lh_sext", ReadDataW, 32'hFFFF8001);
        load(3'b101, 32'h12, 5'd6); step();
        chk("lhu_zext", ReadDataW, 32'h00008001);
        load(3'b000, 32'h10, 5'd6); step();
        chk("lb_lane0", ReadDataW, 32'hFFFFFFEF);
        load(3'b011, 32'h10, 5'd6); step();
        chk("bad_f3_load", ReadDataW, 32'h0);

        load(3'b010, 32'h11, 5'd7); step();
        chk("mis_lw_data", ReadDataW, 32'h0);
        chk("mis_lw_regwrite", {31'h0, RegWriteW}, 32'h0);
        chk("mis_lw_flag", {31'h0, MisalignW}, 32'h1);
        store(3'b010, 32'h14, 32'h11223344); step();
        chk("aligned_flag", {31'h0, MisalignW}, 32'h0);
        store(3'b001, 32'h15, 32'h0000FFFF); step();
        chk("mis_sh_flag", {31'h0, MisalignW}, 32'h1);
        load(3'b010, 32'h14, 5'd8); step();
        chk("mis_sh_nowrite", ReadDataW, 32'h11223344);
        chk("mis_flag_clears", {31'h0, MisalignW}, 32'h0);

        store(3'b010, 32'h20, 32'h55667788); step();
        load(3'b010, 32'h20, 5'd9); step();
        store(3'b010, 32'h20, 32'hCAFEF00D); StallM = 1; step();
        chk("stall_data_hold", ReadDataW, 32'h55667788);
        chk("stall_rd_hold", {27'h0, RD_W}, 32'd9);
        chk("stall_regw_hold", {31'h0, RegWriteW}, 32'h1);
        chk("stall_src_hold", {30'h0, ResultSrcW}, 32'h1);
        load(3'b010, 32'h20, 5'd10); step();
        chk("stall_nowrite", ReadDataW, 32'h55667788);
        store(3'b010, 32'h20, 32'h0BADF00D); RegWriteM = 1; RD_M = 5'd3;
        StallM = 1; FlushM = 1; step();
        chk("flush_regwrite", {31'h0, RegWriteW}, 32'h0);
        chk("flush_rd", {27'h0, RD_W}, 32'd0);
        chk("flush_src", {30'h0, ResultSrcW}, 32'h0);
        load(3'b010, 32'h20, 5'd11); step();
        chk("flush_nowrite", ReadDataW, 32'h55667788);

        store(3'b010, 32'h1000, 32'h12345678); step();
        load(3'b010, 32'h0, 5'd12); step();
        chk("wrap_lw", ReadDataW, 32'h12345678);

        load(3'b010, 32'h0, 5'd4); step();
        chk("pre_rst_regwrite", {31'h0, RegWriteW}, 32'h1);
        store(3'b010, 32'h0, 32'hFFFFFFFF); RegWriteM = 1; RD_M = 5'd4;
        #2 rst = 0; #1;
        chk("async_rst_regwrite", {31'h0, RegWriteW}, 32'h0);
        chk("async_rst_rd", {27'h0, RD_W}, 32'd0);
        chk("async_rst_data", ReadDataW, 32'h0);
        chk("async_rst_alures", ALUResultW, 32'h0);
        step();
        chk("rst_hold_pc", PCPlus4W, 32'h0);
        rst = 1;
        load(3'b010, 32'h0, 5'd4); step();
        chk("post_rst_data", ReadDataW, 32'h12345678);
        chk("post_rst_regwrite", {31'h0, RegWriteW}, 32'h1);
        chk("post_rst_rd", {27'h0, RD_W}, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- MEM stage of the 5-stage RISC-V pipeline. It sits between the execute stage and writeback_cycle.
- Performs load/store access to an internal word-organised data memory, with RV32I byte/halfword/word sizing and load sign/zero extension.
- Registers the MEM/WB pipeline signals that feed the writeback stage.
- Also provides stall, flush and misalignment handling.

Parameters:
- DEPTH, 1024, number of 32-bit words in data memory (power of two).
- ADDR_W, 10, word-index width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  asynchronous, active-low reset
- RegWriteM  input  1  register-file write enable from execute
- MemWriteM  input  1  store request
- ResultSrcM  input  2  result select, passed through (00 ALU, 01 load, 10 PC+4)
- funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- RD_M  input  5  destination register
- ALUResultM  input  32  effective address / ALU result
- WriteDataM  input  32  store data (rs2)
- PCPlus4M  input  32  PC+4
- StallM  input  1  hold MEM/WB registers, suppress store
- FlushM  input  1  insert bubble into WB
- RegWriteW  output  1  registered write enable to writeback
- ResultSrcW  output  2  registered result select
- RD_W  output  5  registered destination
- ALUResultW  output  32  registered ALU result
- ReadDataW  output  32  registered, extended load data
- PCPlus4W  output  32  registered PC+4
- MisalignW  output  1  registered misaligned-access flag

Behaviour:
Reset
- rst low forces all outputs and MEM/WB registers to 0 immediately (asynchronous).
- Memory contents are not reset.
- Reset mid-store: the store in that cycle is discarded.

Addressing
- Word index = ALUResultM[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH*4 bytes.
- Byte lane = ALUResultM[1:0].

Misalignment
- An access is misaligned when H/HU has addr[0]=1, or W has addr[1:0]≠00. It is only evaluated for loads (ResultSrcM=01) or stores.
- A misaligned store writes nothing.
- A misaligned load yields ReadDataW=0 and forces RegWriteW=0.
- MisalignW=1 for one registered cycle in either case.

Stores
- Synchronous write on posedge when MemWriteM=1, aligned, StallM=0, FlushM=0 and rst high.
- SB writes WriteDataM[7:0] into the addressed lane only.
- SH writes WriteDataM[15:0] into lanes {1,0} or {3,2}.
- SW writes all 4 lanes.
- Store with funct3 not in {000,001,010}: no write.

Loads
- Combinational read of the addressed word, lane-select and extend, then captured into ReadDataW at posedge.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Load with any other funct3 gives ReadDataW=0.
- Latency: one cycle, i.e. values presented in cycle N appear on W outputs after posedge ending N.
- A store in cycle N followed by a load of the same address in cycle N+1 returns the new data (write-then-read).
- A single instruction per cycle means no simultaneous load and store.

MEM/WB register update priority
- FlushM=1 (beats StallM): RegWriteW=0, RD_W=0, MisalignW=0, ResultSrcW=0; data outputs are don't-care, driven 0.
- Else StallM=1: all W outputs hold their values.
- Else: capture all fields.
- ReadDataW is captured every unstalled cycle regardless of ResultSrcM.

Test Plan:
- Reset: rst low mid-run with RegWriteM=1 → all W outputs 0 asynchronously; after release, first posedge captures normally.
- SW 0xDEADBEEF to 0x10, then LW 0x10 next cycle → ReadDataW=0xDEADBEEF, ResultSrcW=01, RegWriteW=1.
- Sub-word access:
  - SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080.
  - Then LW 0x10 → 0x80ADBEEF.
  - SH 0x8001 to 0x12 then LH 0x12 → 0xFFFF8001.
- Misalignment:
  - LW at 0x11 → ReadDataW=0, RegWriteW=0, MisalignW=1.
  - SH to 0x15 → memory unchanged (confirmed by LW 0x14), MisalignW=1.
- Stall/flush:
  - StallM=1 with SW to 0x20 → W outputs held, no write (LW 0x20 returns old value).
  - FlushM=1 with StallM=1 → RegWriteW=0, RD_W=0, no write.
- Wrap: with DEPTH=1024, SW 0x12345678 to 0x1000 then LW 0x0 → 0x12345678.
